// File: rtl/fetch_unit.sv
// Instruction fetch PC register plus a synchronised, rate-limited interrupt
// request path that hands one-cycle interrupt pulses to control.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [7:0]  RESET_VECTOR = 8'h00,
  parameter int unsigned IRQ_HOLDOFF  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pc_jump,
  input  logic [7:0] pc_jmpaddr,
  input  logic       pc_freeze,
  input  logic       irq_in,
  input  logic       irq_enable,
  output logic [7:0] datamem_address,
  output logic       interrupt,
  output logic       irq_pending
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;
  localparam logic [3:0] HOLDOFF_LOAD = 4'(IRQ_HOLDOFF);

  logic [7:0] pc_q, pc_d;
  logic       sync1_q, sync2_q, prev_q;
  logic [1:0] flush_q;
  logic       arm_q;
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       latch_q, latch_d;
  logic       intr_q, intr_d;
  logic       pend_q, pend_d;
  logic       req_event;
  logic       issue_ok;

  always_comb begin
    pc_d = pc_q + 8'd1;
    if (pc_jump) begin
      pc_d = pc_jmpaddr;
    end else if (pc_freeze) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Events are only armed once the synchroniser has flushed its reset values
  // and seen irq_in low, so a level held high through reset never fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      flush_q <= 2'b00;
      arm_q   <= 1'b0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      flush_q <= {flush_q[0], 1'b1};
      if (flush_q[1] && !sync2_q) begin
        arm_q <= 1'b1;
      end
    end
  end

  assign req_event = arm_q & sync2_q & ~prev_q;
  assign issue_ok  = ~pc_jump & ~pc_freeze & irq_enable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    intr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_event && irq_enable) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (issue_ok) begin
          intr_d  = 1'b1;
          cnt_d   = HOLDOFF_LOAD;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        cnt_d = cnt_q - 4'd1;
        if (req_event && irq_enable) begin
          latch_d = 1'b1;
        end
        // A request landing on the final holdoff cycle is still carried over.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = latch_d ? PENDING : IDLE;
          latch_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        latch_d = 1'b0;
      end
    endcase
    pend_d = (state_d == PENDING) || ((state_d == HOLDOFF) && latch_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      latch_q <= 1'b0;
      intr_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      intr_q  <= intr_d;
      pend_q  <= pend_d;
    end
  end

  assign datamem_address = pc_q;
  assign interrupt       = intr_q;
  assign irq_pending     = pend_q;

endmodule
